// File: rtl/uart_pkg.sv
// uart_pkg
// Definitions shared by the UART transmitter and its testbench:
//   tx_state_t            - transmitter FSM states
//   DATA_BITS, STOP_BITS  - 8N1 frame shape
//   DEFAULT_CLKS_PER_BIT  - default clk cycles per serial bit
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int DATA_BITS            = 8;
    localparam int STOP_BITS            = 1;
    localparam int DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
// Single-clock FIFO with a registered occupancy count. The head entry is
// presented combinationally from the storage array, so a pop consumes the
// value visible on head in the same cycle.
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset (flushes pointers and count)
//   push   in   write din at the tail (ignored when full)
//   din    in   WIDTH-bit write data
//   pop    in   advance the head (ignored when empty)
//   head   out  WIDTH-bit oldest entry
//   count  out  number of stored entries, 0..DEPTH
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             wr_en;
    logic             rd_en;

    // Guard locally as well, so the FIFO stays consistent even if a caller
    // ignores its own flow control.
    assign wr_en = push && (count_q != CNT_W'(DEPTH));
    assign rd_en = pop && (count_q != '0);

    // DEPTH is a power of two, so pointer overflow wraps modulo DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

    assign head  = mem[rd_ptr];
    assign count = count_q;

endmodule

// File: rtl/uart_tx.sv
// uart_tx
// 8N1 serial transmitter fed by a small byte FIFO. Bytes accepted on
// valid & ready are queued and sent LSB first; consecutive queued bytes are
// sent back to back with no idle gap between stop and next start bit.
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset; aborts any frame, flushes FIFO
//   data_in  in   byte to send, sampled on the accept edge
//   valid    in   data_in is offered
//   ready    out  FIFO has room (count < FIFO_DEPTH)
//   dout     out  registered serial line, idle high
//   busy     out  frame in progress or bytes queued
//
// state | meaning
// IDLE  | line high, waiting for a queued byte
// START | start bit (low) for CLKS_PER_BIT cycles
// DATA  | data bits, shift[0] on the line, LSB first
// STOP  | stop bit (high); then next frame or IDLE
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 valid,
    output logic                 ready,
    output logic                 dout,
    output logic                 busy
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_BITS);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    tx_state_t             state_q, state_d;
    logic [BAUD_W-1:0]     baud_q, baud_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic                  dout_q, dout_d;

    logic                  push;
    logic                  pop;
    logic                  load;
    logic                  bit_end;
    logic [DATA_BITS-1:0]  fifo_head;
    logic [CNT_W-1:0]      fifo_count;

    assign ready = (fifo_count < CNT_W'(FIFO_DEPTH));
    assign push  = valid && ready;
    assign busy  = (state_q != IDLE) || (fifo_count != '0);
    assign dout  = dout_q;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (data_in),
        .pop   (pop),
        .head  (fifo_head),
        .count (fifo_count)
    );

    // Baud timer counts down from CLKS_PER_BIT-1; zero marks the last cycle
    // of the current bit.
    assign bit_end = (baud_q == '0);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        dout_d  = dout_q;
        load    = 1'b0;

        case (state_q)
            IDLE: begin
                dout_d = 1'b1;
                load   = (fifo_count != '0);
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    baud_d  = BAUD_LAST;
                    bit_d   = '0;
                    dout_d  = shift_q[0];
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d  = BAUD_LAST;
                    shift_d = shift_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        state_d = STOP;
                        bit_d   = '0;
                        dout_d  = 1'b1;
                    end else begin
                        bit_d  = bit_q + BIT_W'(1);
                        dout_d = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (bit_q == STOP_LAST) begin
                        // Chain straight into the next start bit when a byte
                        // is waiting, otherwise fall back to IDLE.
                        state_d = IDLE;
                        bit_d   = '0;
                        dout_d  = 1'b1;
                        load    = (fifo_count != '0);
                    end else begin
                        bit_d  = bit_q + BIT_W'(1);
                        baud_d = BAUD_LAST;
                    end
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                dout_d  = 1'b1;
            end
        endcase

        if (load) begin
            state_d = START;
            shift_d = fifo_head;
            baud_d  = BAUD_LAST;
            bit_d   = '0;
            dout_d  = 1'b0;
        end
    end

    assign pop = load;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            dout_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            dout_q  <= dout_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx
// Directed tests for uart_tx: two instances, CLKS_PER_BIT=4 (main) and
// CLKS_PER_BIT=2 (minimum baud counter). A behavioural receiver decodes the
// main instance's serial line into a queue for loopback comparison.
module tb_uart_tx;

    localparam int C_A = 4;
    localparam int C_B = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_a, data_b;
    logic       valid_a, valid_b;
    logic       ready_a, ready_b;
    logic       dout_a, dout_b;
    logic       busy_a, busy_b;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx #(.CLKS_PER_BIT(C_A), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .rst(rst), .data_in(data_a), .valid(valid_a),
        .ready(ready_a), .dout(dout_a), .busy(busy_a)
    );

    uart_tx #(.CLKS_PER_BIT(C_B), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .data_in(data_b), .valid(valid_b),
        .ready(ready_b), .dout(dout_b), .busy(busy_b)
    );

    // ---------------- behavioural receiver on dut_a ----------------
    logic       rx_en = 1'b0;
    logic [7:0] rx_q[$];
    int         rx_t[$];
    int         rx_ferr = 0;
    int         mon_t0;
    logic [7:0] mon_b;
    logic       mon_ok;

    initial forever begin
        @(posedge clk); #2;
        if (rx_en && dout_a === 1'b0) begin
            mon_t0 = cyc;
            mon_ok = 1'b1;
            repeat (C_A / 2) @(posedge clk);
            #2;
            if (dout_a !== 1'b0) mon_ok = 1'b0;
            for (int i = 0; i < 8; i++) begin
                repeat (C_A) @(posedge clk);
                #2;
                mon_b[i] = dout_a;
            end
            repeat (C_A) @(posedge clk);
            #2;
            if (dout_a !== 1'b1) mon_ok = 1'b0;
            if (!mon_ok) rx_ferr++;
            rx_q.push_back(mon_b);
            rx_t.push_back(mon_t0);
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        valid_a = 1'b1; data_a = 8'hEE;
        valid_b = 1'b1; data_b = 8'hEE;
        repeat (3) tick();
        checks++; if (dout_a !== 1'b1) begin errors++; $display("FAIL reset_dout_a: got %b expected 1", dout_a); end
        checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL reset_ready_a: got %b expected 1", ready_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy_a: got %b expected 0", busy_a); end
        checks++; if (dout_b !== 1'b1) begin errors++; $display("FAIL reset_dout_b: got %b expected 1", dout_b); end
        checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL reset_busy_b: got %b expected 0", busy_b); end
        rst = 1'b0; valid_a = 1'b0; valid_b = 1'b0;
        tick();
        // valid held during reset must not have queued anything
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_valid_ignored: busy got %b expected 0", busy_a); end
        checks++; if (dout_a !== 1'b1) begin errors++; $display("FAIL reset_idle_line: got %b expected 1", dout_a); end
    endtask

    task automatic test_single_a5();
        logic [7:0] b;
        logic       exp;
        b = 8'hA5;
        data_a = b; valid_a = 1'b1;
        checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL a5_ready: got %b expected 1", ready_a); end
        tick();
        valid_a = 1'b0;
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL a5_busy_after_accept: got %b expected 1", busy_a); end
        checks++; if (dout_a !== 1'b1) begin errors++; $display("FAIL a5_dout_at_accept: got %b expected 1", dout_a); end
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k <= 4)       exp = 1'b0;
            else if (k > 36)  exp = 1'b1;
            else              exp = b[(k - 5) / 4];
            checks++; if (dout_a !== exp) begin errors++; $display("FAIL a5_dout cycle %0d: got %b expected %b", k, dout_a, exp); end
        end
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL a5_busy_last_stop: got %b expected 1", busy_a); end
        tick();
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL a5_busy_done: got %b expected 0", busy_a); end
        checks++; if (dout_a !== 1'b1) begin errors++; $display("FAIL a5_dout_idle: got %b expected 1", dout_a); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [4];
        int t_acc, guard;
        bytes = '{8'h00, 8'hFF, 8'h55, 8'h3C};
        rx_q.delete(); rx_t.delete(); rx_ferr = 0; rx_en = 1'b1;
        t_acc = 0;
        for (int i = 0; i < 4; i++) begin
            data_a = bytes[i]; valid_a = 1'b1;
            tick();
            if (i == 0) t_acc = cyc;
            // first byte is popped on the next edge, so count peaks at 3: ready stays high
            checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL b2b_ready push %0d: got %b expected 1", i, ready_a); end
        end
        valid_a = 1'b0;
        guard = 0;
        while (busy_a !== 1'b0 && guard < 400) begin tick(); guard++; end
        checks++; if (cyc !== t_acc + 161) begin errors++; $display("FAIL b2b_total_time: busy fell at %0d expected %0d", cyc - t_acc, 161); end
        repeat (4) tick();
        checks++; if (rx_q.size() !== 4) begin errors++; $display("FAIL b2b_frame_count: got %0d expected 4", rx_q.size()); end
        for (int i = 0; i < 4 && i < rx_q.size(); i++) begin
            checks++; if (rx_q[i] !== bytes[i]) begin errors++; $display("FAIL b2b_byte %0d: got %h expected %h", i, rx_q[i], bytes[i]); end
        end
        if (rx_t.size() >= 1) begin
            checks++; if (rx_t[0] !== t_acc + 1) begin errors++; $display("FAIL b2b_first_start: got %0d expected %0d", rx_t[0] - t_acc, 1); end
        end
        for (int i = 1; i < rx_t.size(); i++) begin
            checks++; if (rx_t[i] - rx_t[i-1] !== 40) begin errors++; $display("FAIL b2b_gap %0d: got %0d expected 40", i, rx_t[i] - rx_t[i-1]); end
        end
        checks++; if (rx_ferr !== 0) begin errors++; $display("FAIL b2b_framing: got %0d expected 0", rx_ferr); end
        rx_en = 1'b0;
    endtask

    task automatic test_full_hold();
        logic [7:0] bytes [6];
        int t_acc, guard, n77;
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h77};
        rx_q.delete(); rx_t.delete(); rx_ferr = 0; rx_en = 1'b1;
        t_acc = 0;
        for (int i = 0; i < 5; i++) begin
            data_a = bytes[i]; valid_a = 1'b1;
            tick();
            if (i == 0) t_acc = cyc;
        end
        checks++; if (ready_a !== 1'b0) begin errors++; $display("FAIL full_ready_low: got %b expected 0", ready_a); end
        data_a = 8'h77; valid_a = 1'b1;
        guard = 0;
        while (ready_a !== 1'b1 && guard < 100) begin tick(); guard++; end
        // first frame ends (and pops) on edge t_acc+41
        checks++; if (cyc !== t_acc + 41) begin errors++; $display("FAIL full_ready_rise: at %0d expected %0d", cyc - t_acc, 41); end
        tick();
        valid_a = 1'b0;
        checks++; if (ready_a !== 1'b0) begin errors++; $display("FAIL full_refilled: ready got %b expected 0", ready_a); end
        guard = 0;
        while (busy_a !== 1'b0 && guard < 600) begin tick(); guard++; end
        checks++; if (cyc !== t_acc + 241) begin errors++; $display("FAIL full_total_time: busy fell at %0d expected %0d", cyc - t_acc, 241); end
        repeat (4) tick();
        checks++; if (rx_q.size() !== 6) begin errors++; $display("FAIL full_frame_count: got %0d expected 6", rx_q.size()); end
        n77 = 0;
        for (int i = 0; i < rx_q.size(); i++) begin
            if (rx_q[i] === 8'h77) n77++;
            if (i < 6) begin
                checks++; if (rx_q[i] !== bytes[i]) begin errors++; $display("FAIL full_byte %0d: got %h expected %h", i, rx_q[i], bytes[i]); end
            end
        end
        checks++; if (n77 !== 1) begin errors++; $display("FAIL full_77_once: got %0d expected 1", n77); end
        rx_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        int t_acc, lows, busys;
        rx_en = 1'b0;
        data_a = 8'hC3; valid_a = 1'b1;
        tick();
        t_acc = cyc;
        data_a = 8'h12; tick();
        data_a = 8'h34; tick();
        valid_a = 1'b0;
        // DATA bit 3 occupies edges t_acc+17 .. t_acc+20
        while (cyc < t_acc + 18) tick();
        checks++; if (dout_a !== 1'b0) begin errors++; $display("FAIL rmid_bit3: got %b expected 0", dout_a); end
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL rmid_busy_before: got %b expected 1", busy_a); end
        rst = 1'b1; valid_a = 1'b1; data_a = 8'h99;
        tick();
        rst = 1'b0; valid_a = 1'b0;
        checks++; if (dout_a !== 1'b1) begin errors++; $display("FAIL rmid_dout: got %b expected 1", dout_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b expected 0", busy_a); end
        checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL rmid_ready: got %b expected 1", ready_a); end
        lows = 0; busys = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (dout_a !== 1'b1) lows++;
            if (busy_a !== 1'b0) busys++;
        end
        checks++; if (lows !== 0) begin errors++; $display("FAIL rmid_no_frames: low cycles got %0d expected 0", lows); end
        checks++; if (busys !== 0) begin errors++; $display("FAIL rmid_stay_idle: busy cycles got %0d expected 0", busys); end
    endtask

    task automatic test_min_baud();
        logic [7:0] b;
        logic       exp;
        b = 8'h81;
        data_b = b; valid_b = 1'b1;
        tick();
        valid_b = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k <= 2)       exp = 1'b0;
            else if (k > 18)  exp = 1'b1;
            else              exp = b[(k - 3) / 2];
            checks++; if (dout_b !== exp) begin errors++; $display("FAIL minbaud_dout cycle %0d: got %b expected %b", k, dout_b, exp); end
        end
        checks++; if (busy_b !== 1'b1) begin errors++; $display("FAIL minbaud_busy_last: got %b expected 1", busy_b); end
        tick();
        checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL minbaud_busy_done: got %b expected 0", busy_b); end
    endtask

    task automatic test_random();
        logic [7:0] exp_q[$];
        int guard, bad;
        rx_q.delete(); rx_t.delete(); rx_ferr = 0; rx_en = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            valid_a = 1'b0;
            repeat ($urandom_range(0, 3)) tick();
            data_a = 8'($urandom);
            valid_a = 1'b1;
            guard = 0;
            while (ready_a !== 1'b1 && guard < 200) begin tick(); guard++; end
            if (guard >= 200) begin
                checks++; errors++;
                $display("FAIL rand_ready_timeout: byte %0d ready stuck at %b expected 1", i, ready_a);
                break;
            end
            exp_q.push_back(data_a);
            tick();
        end
        valid_a = 1'b0;
        guard = 0;
        while (busy_a !== 1'b0 && guard < 1000) begin tick(); guard++; end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rand_drain: busy got %b expected 0", busy_a); end
        repeat (4) tick();
        checks++; if (rx_q.size() !== exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d expected %0d", rx_q.size(), exp_q.size()); end
        bad = 0;
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            if (rx_q[i] !== exp_q[i]) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL rand_bytes: mismatched bytes got %0d expected 0", bad); end
        checks++; if (rx_ferr !== 0) begin errors++; $display("FAIL rand_framing: got %0d expected 0", rx_ferr); end
        rx_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        valid_a = 1'b0; data_a = 8'h00;
        valid_b = 1'b0; data_b = 8'h00;
        tick();
        test_reset();
        test_single_a5();
        test_back_to_back();
        test_full_hold();
        test_reset_mid();
        test_min_baud();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The module SHALL have one clock and synchronous active-high reset. Ports SHALL be named clk and rst.
REQ-002 Parameter CLKS_PER_BIT SHALL default to 868 and gives the clk cycles per serial bit. Legal range is 2..65535.
REQ-003 Parameter FIFO_DEPTH SHALL default to 4 and gives the transmit FIFO entries. It SHALL be a power of two, at least 2.
REQ-004 clk  input  1  system clock; all logic rising-edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 data_in  input  8  byte to transmit; sampled only on the accept edge.
REQ-007 valid  input  1  data_in is offered.
REQ-008 ready  output  1  FIFO can accept a byte.
REQ-009 dout  output  1  serial line: idle high, 8N1, LSB first.
REQ-010 busy  output  1  a frame is in progress or the FIFO is non-empty.

Function
REQ-011 A byte SHALL be accepted on a clk edge where valid=1 and ready=1, and written to the FIFO tail.
REQ-012 ready SHALL equal (FIFO count < FIFO_DEPTH) and SHALL be combinational from registered count only.
REQ-013 Offers with valid=1 and ready=0 SHALL be ignored; the FIFO and count SHALL stay unchanged.
REQ-014 The FSM SHALL have four states: IDLE, START, DATA, STOP.
REQ-015 IDLE with FIFO non-empty: on the next edge, pop the head into the shift register, reset the baud counter, enter START, and drive dout=0.
REQ-016 START SHALL hold dout=0 for exactly CLKS_PER_BIT cycles, then enter DATA with bit index 0.
REQ-017 DATA SHALL drive shift[0] for CLKS_PER_BIT cycles per bit, shifting right after each bit. After bit index 7 it SHALL enter STOP.
REQ-018 STOP SHALL drive dout=1 for CLKS_PER_BIT cycles.
REQ-019 On leaving STOP, the FSM SHALL enter START directly if the FIFO is non-empty (back-to-back, no idle gap), otherwise IDLE.
REQ-020 A frame SHALL be exactly 10*CLKS_PER_BIT cycles.
REQ-021 Latency: with IDLE and an empty FIFO, dout SHALL fall on the first edge after the accept edge.
REQ-022 dout SHALL be registered (glitch-free) and SHALL be 1 in IDLE.
REQ-023 A simultaneous push and pop SHALL both take effect, with the count unchanged.
REQ-024 A push into a FIFO being popped while full SHALL not occur, because ready=0.
REQ-025 Pointers SHALL wrap modulo FIFO_DEPTH. The count SHALL be $clog2(FIFO_DEPTH)+1 bits.
REQ-026 The baud counter SHALL be $clog2(CLKS_PER_BIT) bits and count 0..CLKS_PER_BIT-1. It SHALL never overflow.
REQ-027 busy SHALL be (state != IDLE) or (count != 0), registered-source only.

Reset
REQ-028 On rst=1 at an edge, all of the following SHALL hold the next cycle:
- state=IDLE, dout=1, ready=1, busy=0
- FIFO flushed: pointers=0, count=0
- baud counter, bit index and shift register cleared
REQ-029 Reset mid-frame SHALL abort the frame immediately, with no stop bit completion, and discard queued bytes.
REQ-030 valid asserted during rst SHALL not be accepted.

Structure
REQ-031 A shared package uart_pkg SHALL hold:
- the tx state enum (IDLE/START/DATA/STOP)
- the frame constants DATA_BITS=8 and STOP_BITS=1
- the default CLKS_PER_BIT
REQ-032 The FIFO SHALL be a separate sub-module, sync_fifo, parameterised on width and depth. The FSM, baud counter and shift register SHALL live in uart_tx.

Verification
REQ-033 With CLKS_PER_BIT=4, idle, push 0xA5: dout SHALL read 0 | 1,0,1,0,0,1,0,1 | 1, each held 4 cycles. dout SHALL fall 1 cycle after accept, and busy=0 after 40 cycles.
REQ-034 With CLKS_PER_BIT=4, push 0x00, 0xFF, 0x55, 0x3C back-to-back: ready SHALL drop after the 4th push only while count=4. Four frames SHALL follow with no idle gap (160 cycles), each byte SHALL be correct in order, and the result SHALL loop back through uart_rx to data_out with valid pulses matching.
REQ-035 With the FIFO full, hold valid=1 with 0x77: it SHALL not be accepted until ready rises one edge after the first pop, and 0x77 SHALL be sent exactly once.
REQ-036 Assert rst during DATA bit 3 of 0xC3 with 2 bytes queued: the next cycle SHALL show dout=1, busy=0 and ready=1, and no further frames SHALL appear.
REQ-037 With CLKS_PER_BIT=2, push 0x81: the total frame SHALL be 20 cycles, exercising the minimum baud-counter width.
REQ-038 A random stream of 1000 bytes with random valid gaps SHALL loop back through uart_rx and match the scoreboard with zero loss or reordering.
